// File: rtl/seq_bit_tx_if.sv
// Word handshake between a producer and the seq_bit_tx serialiser.
// WIDTH must match the WIDTH of the seq_bit_tx instance it connects to.
interface seq_bit_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/seq_bit_tx.sv
// Parallel-to-serial transmitter: words enter a small FIFO through a valid/ready
// handshake and leave MSB-first on dout, one bit per bit_en tick, with no gap between words.
module seq_bit_tx #(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  seq_bit_tx_if.slave              bus,
  input  logic                     bit_en,
  output logic                     dout,
  output logic                     dout_valid,
  output logic                     frame_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [0:0]       state;
  logic             push, pop, word_end;

  // Ready looks only at the count, so a full FIFO refuses a push even while popping.
  assign bus.data_ready = (count < CW'(DEPTH));
  assign push           = bus.data_valid & bus.data_ready;
  assign word_end       = (state == IDLE) || (bitcnt == '0);
  assign pop            = bit_en && (count != '0) && word_end;
  assign busy           = (state == SHIFT) || (count != '0);
  assign fifo_count     = count;

  // NOTE: the storage array has no reset; emptiness is tracked by the pointers and
  // count alone, which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bit_en) begin
        if (pop) begin
          // Fresh word (from IDLE or straight after the previous LSB): load MSB.
          shreg      <= mem[rd_ptr];
          dout       <= mem[rd_ptr][WIDTH-1];
          dout_valid <= 1'b1;
          bitcnt     <= BW'(WIDTH - 1);
          frame_done <= (WIDTH == 1);
          state      <= SHIFT;
        end else if ((state == SHIFT) && (bitcnt != '0)) begin
          dout       <= shreg[bitcnt - BW'(1)];
          bitcnt     <= bitcnt - BW'(1);
          frame_done <= (bitcnt == BW'(1));
        end else begin
          dout       <= IDLE_BIT;
          dout_valid <= 1'b0;
          state      <= IDLE;
        end
      end
    end
  end

endmodule
